// File: rtl/paddle_bank_pkg.sv
// rtl/paddle_bank_pkg.sv - shared game constants and paddle command encoding
package paddle_bank_pkg;

  localparam int POSITION_WIDTH = 10;
  localparam int FIELD_POS_MIN  = 0;
  localparam int FIELD_POS_MAX  = 479;

  // Encoded as {move_backward, move_forward}
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_FWD  = 2'b01,
    CMD_BWD  = 2'b10,
    CMD_BOTH = 2'b11
  } move_cmd_e;

endpackage

// File: rtl/frame_tick.sv
// rtl/frame_tick.sv - one-cycle tick on the rising edge of vertical_sync
module frame_tick (
  input  logic pixel_clock,
  input  logic reset_n,
  input  logic vertical_sync,
  output logic tick
);

  logic vsync_prev;

  // Resetting to 1 suppresses a tick when vsync is already high at reset release
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) vsync_prev <= 1'b1;
    else          vsync_prev <= vertical_sync;
  end

  assign tick = vertical_sync & ~vsync_prev;

endmodule

// File: rtl/paddle_bank.sv
// rtl/paddle_bank.sv - bank of independent accelerating paddles with field clamping
module paddle_bank
  import paddle_bank_pkg::*;
#(
  parameter int N_PADDLES     = 2,
  parameter int POS_WIDTH     = POSITION_WIDTH,
  parameter int PADDLE_LENGTH = 200,
  parameter int SPEED_MAX     = 10,
  parameter int ACCEL         = 2,
  parameter int POS_MIN       = FIELD_POS_MIN,
  parameter int POS_MAX       = FIELD_POS_MAX,
  parameter int START_POS     = 110
) (
  input  logic                           pixel_clock,
  input  logic                           reset_n,
  input  logic                           vertical_sync,
  input  logic                           enable,
  input  logic [N_PADDLES-1:0]           move_forward,
  input  logic [N_PADDLES-1:0]           move_backward,
  output logic [N_PADDLES*POS_WIDTH-1:0] paddle_pos,
  output logic [N_PADDLES-1:0]           at_min,
  output logic [N_PADDLES-1:0]           at_max,
  output logic [N_PADDLES-1:0]           bump
);

  localparam int VW = $clog2(SPEED_MAX + 1) + 1;
  localparam int SW = POS_WIDTH + 2;

  localparam logic signed [SW-1:0] LIM_LO = SW'(POS_MIN);
  localparam logic signed [SW-1:0] LIM_HI = SW'(POS_MAX - PADDLE_LENGTH);
  localparam logic signed [VW:0]   V_MAX  = (VW+1)'(SPEED_MAX);
  localparam logic signed [VW:0]   V_ACC  = (VW+1)'(ACCEL);

  if (ACCEL < 1 || ACCEL > SPEED_MAX || POS_MIN + PADDLE_LENGTH > POS_MAX) begin : g_bad_params
    $error("paddle_bank: illegal ACCEL/SPEED_MAX/field parameters");
  end

  logic tick;

  frame_tick u_frame_tick (
    .pixel_clock   (pixel_clock),
    .reset_n       (reset_n),
    .vertical_sync (vertical_sync),
    .tick          (tick)
  );

  for (genvar i = 0; i < N_PADDLES; i++) begin : g_ch
    logic        [POS_WIDTH-1:0] pos_q, pos_d;
    logic signed [VW-1:0]        vel_q, vel_d;
    logic signed [VW:0]          v_ext, v_sum;
    logic signed [SW-1:0]        pos_sum;
    logic                        bump_q, clamp, v_neg, v_pos;
    move_cmd_e                   cmd;

    always_comb begin
      cmd   = move_cmd_e'({move_backward[i], move_forward[i]});
      v_ext = {vel_q[VW-1], vel_q};
      v_sum = '0;
      case (cmd)
        CMD_FWD: v_sum = (v_ext + V_ACC > V_MAX)  ? V_MAX  : v_ext + V_ACC;
        CMD_BWD: v_sum = (v_ext - V_ACC < -V_MAX) ? -V_MAX : v_ext - V_ACC;
        default: begin
          // Decay toward zero without crossing it
          if (v_ext > V_ACC)       v_sum = v_ext - V_ACC;
          else if (v_ext < -V_ACC) v_sum = v_ext + V_ACC;
          else                     v_sum = '0;
        end
      endcase

      v_neg   = v_sum[VW];
      v_pos   = !v_sum[VW] && (v_sum != '0);
      pos_sum = $signed({2'b00, pos_q}) + $signed({{(SW-VW-1){v_sum[VW]}}, v_sum});
      vel_d   = v_sum[VW-1:0];
      pos_d   = pos_sum[POS_WIDTH-1:0];
      clamp   = 1'b0;
      // Arriving at or beyond a limit while moving into it counts as a clamp
      if (v_neg && pos_sum <= LIM_LO) begin
        clamp = 1'b1;
        pos_d = LIM_LO[POS_WIDTH-1:0];
        vel_d = '0;
      end else if (v_pos && pos_sum >= LIM_HI) begin
        clamp = 1'b1;
        pos_d = LIM_HI[POS_WIDTH-1:0];
        vel_d = '0;
      end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
        pos_q  <= POS_WIDTH'(START_POS);
        vel_q  <= '0;
        bump_q <= 1'b0;
      end else if (tick && enable) begin
        pos_q  <= pos_d;
        vel_q  <= vel_d;
        bump_q <= clamp;
      end else begin
        bump_q <= 1'b0;
      end
    end

    assign paddle_pos[i*POS_WIDTH +: POS_WIDTH] = pos_q;
    assign at_min[i] = (pos_q == LIM_LO[POS_WIDTH-1:0]);
    assign at_max[i] = (pos_q == LIM_HI[POS_WIDTH-1:0]);
    assign bump[i]   = bump_q;
  end

endmodule

// File: doc/paddle_bank.md
PADDLE_BANK -- requirements
Module: paddle_bank

Interface
REQ-001 SHALL have parameter N_PADDLES, default 2, number of independent paddle channels.
REQ-002 SHALL have parameter POS_WIDTH, default `POSITION_WIDTH, position bus width per channel.
REQ-003 SHALL have parameter PADDLE_LENGTH, default 200, paddle extent along the motion axis.
REQ-004 SHALL have parameter SPEED_MAX, default 10, maximum velocity magnitude, in units per frame.
REQ-005 SHALL have parameter ACCEL, default 2, velocity change per frame tick.
REQ-006 SHALL have parameters POS_MIN, default 0, and POS_MAX, default 479, inclusive field limits.
REQ-007 SHALL have parameter START_POS, default 110, reset position of every channel.
REQ-008 SHALL have port pixel_clock, input, 1, the single clock.
REQ-009 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port vertical_sync, input, 1, frame sync; its rising edge defines a frame tick.
REQ-011 SHALL have port enable, input, 1, gates motion updates.
REQ-012 SHALL have ports move_forward and move_backward, input, N_PADDLES, per-channel controls, with bit i belonging to channel i.
REQ-013 SHALL have port paddle_pos, output, N_PADDLES*POS_WIDTH, packed positions, with channel i at bits [i*POS_WIDTH +: POS_WIDTH].
REQ-014 SHALL have ports at_min and at_max, output, N_PADDLES, level flags that are high while the channel sits at the lower or upper limit.
REQ-015 SHALL have port bump, output, N_PADDLES, a one-cycle pulse when a channel is clamped by a limit.

Function
REQ-016 SHALL generate the tick as vertical_sync high while the registered previous vertical_sync is low; all channel updates SHALL occur on the pixel_clock edge that samples the tick.
REQ-017 SHALL keep a signed velocity per channel, with width $clog2(SPEED_MAX+1)+1, range -SPEED_MAX..+SPEED_MAX.
REQ-018 SHALL, on a tick with enable=1, compute the velocity per channel:
- forward only: v = min(v+ACCEL, SPEED_MAX).
- backward only: v = max(v-ACCEL, -SPEED_MAX).
- neither or both: v moves toward 0 by ACCEL, without overshooting 0.
REQ-019 SHALL compute the next position as pos + v_new in POS_WIDTH+2 signed arithmetic, so that no wrap-around occurs.
REQ-020 SHALL clamp the next position to the range [POS_MIN, POS_MAX-PADDLE_LENGTH]; on a clamp, velocity SHALL be 0 and bump SHALL pulse for exactly that one cycle.
REQ-021 SHALL NOT pulse bump when a channel already at a limit with v_new=0 is not pushed further.
REQ-022 SHALL derive at_min and at_max combinationally from the registered position, as pos==POS_MIN and pos==POS_MAX-PADDLE_LENGTH respectively.
REQ-023 SHALL, with enable=0, ignore ticks, hold position and velocity, and keep bump at 0.
REQ-024 SHALL update all channels independently and concurrently; one channel's inputs SHALL NOT affect another channel.
REQ-025 SHALL fail elaboration unless ACCEL>=1, ACCEL<=SPEED_MAX and POS_MIN+PADDLE_LENGTH<=POS_MAX.

Reset
REQ-026 SHALL, on reset_n low (asynchronous), set every position to START_POS, every velocity to 0 and bump to 0.
REQ-027 SHALL, on reset_n low, set the previous-vsync register to 1, so that no tick occurs if vertical_sync is high at reset release.
REQ-028 SHALL, on a reset asserted mid-frame, discard any pending tick; motion SHALL resume on the next genuine rising edge of vertical_sync.

Structure
REQ-029 SHALL take POSITION_WIDTH from the shared game-constants package.
REQ-030 SHALL place the field-limit defaults POS_MIN and POS_MAX in that same package.
REQ-031 SHALL place the tick logic in sub-module frame_tick (ports: pixel_clock, reset_n, vertical_sync, tick), reusable by ball and score blocks.
REQ-032 SHALL implement per-channel logic with a generate loop over N_PADDLES.

Verification
(All scenarios use default parameters.)
REQ-033 SHALL cover: forward held on ch0 for 6 ticks -> pos 112,116,122,130,140,150; ch1 stays 110.
REQ-034 SHALL cover: ch0 at 150 with v=10, then neither pressed -> v 8,6,4,2,0; pos 158,164,168,170,170.
REQ-035 SHALL cover: ch0 at 275 with v=+10, forward held -> pos 279, at_max=1, one-cycle bump, v=0; the next tick gives v=2 and re-clamps with another bump.
REQ-036 SHALL cover: ch1 at 4 with v=-6, both pressed -> v=-4, pos 0, at_min=1, bump, v=0.
REQ-037 SHALL cover: reset_n pulsed low while vertical_sync is high and released while it is still high -> no update until vertical_sync falls and rises again; positions read 110.
REQ-038 SHALL cover: enable=0 across 3 ticks with forward held -> positions and velocities unchanged, bump stays 0.
